param_datapath: RTL
===================

Name: param_datapath

Overview:
- Parametrised successor to the team's fixed 8-bit RA/RB/RZ adder datapath.
- Provides a register file of NUM_REGS x WIDTH, a single internal bus and a Y operand latch.
- Provides an 8-op ALU with Z result and carry registers.
- A small control FSM sequences each accepted op through bus-driven micro-steps (read A, read B/compute, write-back) under a valid/ready handshake.
- An external host port preloads and inspects registers.

Parameters:
- WIDTH, 8, data/register width in bits (>=4).
- NUM_REGS, 4, register count; power of two, >=2.
- RAW, $clog2(NUM_REGS), register address width (derived, not overridden).

Ports:
- clock  in  1  single clock, rising edge.
- clear  in  1  synchronous, active-low reset.
- op_valid  in  1  op request.
- op_ready  out  1  high when FSM in IDLE.
- op_code  in  3  ALU operation.
- op_srca  in  RAW  source A register.
- op_srcb  in  RAW  source B register.
- op_dst  in  RAW  destination register.
- done  out  1  one-cycle pulse after write-back.
- result  out  WIDTH  Z register contents.
- carry  out  1  carry/borrow register.
- zhi  out  WIDTH  multiply high half (optional feature).
- write_enable  in  1  host register write.
- write_addr  in  RAW  host write address.
- write_data  in  WIDTH  host write data.
- read_addr  in  RAW  host read address.
- read_data  out  WIDTH  combinational R[read_addr].

Behaviour:
- Reset: clear==0 at a rising edge → all R[i], Y, Z, carry, zhi = 0; state=IDLE; done=0; op_ready=1.
- Reset mid-op aborts the op: no write-back, no done.
- FSM states: IDLE → T_A → T_B → T_W → IDLE.
- IDLE: op_ready=1. On op_valid&&op_ready at edge C0: latch op_code/srca/srcb/dst into internal regs; go T_A. Inputs are ignored after acceptance.
- T_A (C1): bus=R[srca]; Y<=bus; go T_B.
- T_B (C2): bus=R[srcb]; Z<=ALU(Y,bus); carry updated; go T_W.
- T_W (C3): bus=Z; R[dst]<=bus; go IDLE; done<=1.
- done: high exactly one cycle (C4). op_ready is 1 in C4, so the next op may be accepted at the C4 edge. Throughput is one op per 4 cycles.
- op_valid while op_ready=0: ignored, not queued.
- Bus source is decided by state only. In IDLE the bus drives 0.
- ALU: all arithmetic modulo 2^WIDTH.
  - 000 ADD: Z=Y+B; carry = bit WIDTH of the sum.
  - 001 SUB: Z=Y-B; carry=1 iff Y<B unsigned (borrow).
  - 010 AND.
  - 011 OR.
  - 100 SHL: Z=Y<<1; carry=Y[WIDTH-1].
  - 101 SHR (logical): Z=Y>>1; carry=Y[0].
  - 110 NOT: Z=~Y; carry=0.
  - 111 PASS B: Z=B; carry=0 (see optional feature).
- Sources may equal each other and/or dst. Reads always use register contents at the read cycle.
- Host write: R[write_addr]<=write_data at the edge when write_enable=1, in any state.
  - A host write to a source register before its read cycle is visible to the op.
- Collision: host write and T_W write-back to the same register in the same cycle → write-back wins; host data lost.
- read_data: combinational, reflects writes from the next cycle onward (no bypass).
- result/carry hold their value until the next T_B.

Optional Feature:
- Macro: PARAM_DATAPATH_MUL_EN.
- Defined: op 111 = MUL unsigned. Full 2*WIDTH product computed in T_B; Z<=low WIDTH bits, zhi<=high WIDTH bits; carry=1 iff zhi≠0. zhi is updated only by MUL.
- Not defined: op 111 = PASS B; zhi tied to 0; no multiplier logic synthesised.

Test Plan:
- Reset/preload (WIDTH=8, NUM_REGS=4): clear low 1 cycle → result=0, carry=0, op_ready=1, all read_data=0. Then host write R1=0x3C, R2=0xC8 → read_data reads them back.
- ADD with carry, R1=0x3C, R2=0xC8: op ADD srca=1, srcb=2, dst=3 accepted at C0 → op_ready=0 for C1–C3; done=1 only in C4; R3=0x04, carry=1, result=0x04.
- SUB borrow then back-to-back SHL:
  - SUB 1-2→0 → R0=0x74, carry=1.
  - SHL srca=0 issued with op_valid held high so it is accepted in C4 → R0=0xE8, carry=0.
  - op_valid pulses during busy cycles produce no extra done.
- Collision and source hazard:
  - Host write R3=0xAA in the same cycle as T_W to dst=3 → R3 holds the ALU result.
  - Host write R2=0x01 during T_A of ADD 1+2 → result uses 0x01.
- Reset mid-op: assert clear during T_B of an op targeting R1=0x3C → no done, R1=0, state IDLE next cycle.
- MUL:
  - With PARAM_DATAPATH_MUL_EN: 0xC8*0x3C → result=0xE0, zhi=0x2E, carry=1.
  - Without the macro, same op → result=0x3C (PASS B), zhi=0.

Source files
------------

// File: rtl/param_datapath.sv
// Parametrised single-bus datapath: register file, Y operand latch, 8-op ALU with Z/carry,
// and a 4-state sequencer. Define PARAM_DATAPATH_MUL_EN to turn op 111 into an unsigned multiply.
module param_datapath #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  localparam int RAW     = $clog2(NUM_REGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [RAW-1:0]   op_srca,
  input  logic [RAW-1:0]   op_srcb,
  input  logic [RAW-1:0]   op_dst,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic [WIDTH-1:0] zhi,
  input  logic             write_enable,
  input  logic [RAW-1:0]   write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [RAW-1:0]   read_addr,
  output logic [WIDTH-1:0] read_data
);

  typedef enum logic [1:0] {IDLE, T_A, T_B, T_W} state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR   = 3'b011,
    OP_SHL = 3'b100, OP_SHR = 3'b101, OP_NOT = 3'b110, OP_LAST = 3'b111
  } op_t;

  state_t           state;
  op_t              code_q;
  logic [RAW-1:0]   srca_q, srcb_q, dst_q;
  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] y_q, z_q;
  logic             carry_q;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu_z;
  logic             alu_c;
  logic [WIDTH:0]   sum, diff;

  assign op_ready  = (state == IDLE);
  assign result    = z_q;
  assign carry     = carry_q;
  assign read_data = regs[read_addr];

  // The bus source is a function of state alone; IDLE drives zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    bus = '0;
    case (state)
      T_A:     bus = regs[srca_q];
      T_B:     bus = regs[srcb_q];
      T_W:     bus = z_q;
      default: bus = '0;
    endcase
  end

  assign sum  = {1'b0, y_q} + {1'b0, bus};
  assign diff = {1'b0, y_q} - {1'b0, bus};

`ifdef PARAM_DATAPATH_MUL_EN
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   zhi_q;
  assign prod = {{WIDTH{1'b0}}, y_q} * {{WIDTH{1'b0}}, bus};
  assign zhi  = zhi_q;

  always_ff @(posedge clock) begin
    if (!clear) begin
      zhi_q <= '0;
    end else if (state == T_B && code_q == OP_LAST) begin
      zhi_q <= prod[2*WIDTH-1:WIDTH];
    end
  end
`else
  assign zhi = '0;
`endif

  always_comb begin
    alu_z = '0;
    alu_c = 1'b0;
    case (code_q)
      OP_ADD: begin alu_z = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
      OP_SUB: begin alu_z = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
      OP_AND: alu_z = y_q & bus;
      OP_OR:  alu_z = y_q | bus;
      OP_SHL: begin alu_z = {y_q[WIDTH-2:0], 1'b0}; alu_c = y_q[WIDTH-1]; end
      OP_SHR: begin alu_z = {1'b0, y_q[WIDTH-1:1]}; alu_c = y_q[0];       end
      OP_NOT: alu_z = ~y_q;
`ifdef PARAM_DATAPATH_MUL_EN
      OP_LAST: begin alu_z = prod[WIDTH-1:0]; alu_c = |prod[2*WIDTH-1:WIDTH]; end
`else
      OP_LAST: alu_z = bus;
`endif
      default: alu_z = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state   <= IDLE;
      done    <= 1'b0;
      code_q  <= OP_ADD;
      srca_q  <= '0;
      srcb_q  <= '0;
      dst_q   <= '0;
      y_q     <= '0;
      z_q     <= '0;
      carry_q <= 1'b0;
      // NOTE: the register file is architecturally cleared by reset, so it is flops, not a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; the write-back below is issued after the
      // host write, so on a same-register collision the write-back is the value that lands.
      done <= 1'b0;
      if (write_enable) regs[write_addr] <= write_data;
      case (state)
        IDLE: if (op_valid) begin
          code_q <= op_t'(op_code);
          srca_q <= op_srca;
          srcb_q <= op_srcb;
          dst_q  <= op_dst;
          state  <= T_A;
        end
        T_A: begin
          y_q   <= bus;
          state <= T_B;
        end
        T_B: begin
          z_q     <= alu_z;
          carry_q <= alu_c;
          state   <= T_W;
        end
        T_W: begin
          regs[dst_q] <= bus;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
